// File: rtl/amber128_pkg.sv
// amber128_pkg: shared constants and types for the amber128 data register
// file and its writeback path.
//   D_XLEN          data word width
//   DATA_REG_AW     register address width
//   DATA_REG_COUNT  number of data registers
//   REG_ZERO        hard-wired zero register (writes are discarded)
//   WB_STARVE_LIMIT default MEM starvation limit for the writeback arbiter
package amber128_pkg;

    localparam int D_XLEN         = 128;
    localparam int DATA_REG_AW    = 4;
    localparam int DATA_REG_COUNT = 16;
    localparam logic [DATA_REG_AW-1:0] REG_ZERO = '0;

    localparam int WB_STARVE_LIMIT = 4;

    // Payload presented by an execution source to the writeback port.
    typedef struct packed {
        logic [DATA_REG_AW-1:0] rd;
        logic [D_XLEN-1:0]      data;
    } amber128_wb_result_s;

endpackage

// File: rtl/amber128_wb_arbiter.sv
// amber128_wb_arbiter: two-way priority arbiter between the ALU (high
// priority) and MEM (low priority) writeback sources, with a starvation
// counter that forces a MEM grant once MEM has been refused STARVE_LIMIT
// consecutive cycles.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   alu_valid_i     ALU result valid
//   mem_valid_i     MEM result valid
//   alu_ready_o     ALU granted this cycle
//   mem_ready_o     MEM granted this cycle
module amber128_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int SC_W         = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic alu_valid_i,
    input  logic mem_valid_i,
    output logic alu_ready_o,
    output logic mem_ready_o
);

    logic [SC_W-1:0] starve_q;
    logic [SC_W-1:0] starve_d;
    logic            starved;

    assign starved     = (starve_q == SC_W'(STARVE_LIMIT));
    assign mem_ready_o = mem_valid_i & (~alu_valid_i | starved);
    assign alu_ready_o = alu_valid_i & ~mem_ready_o;

    // Counts consecutive refused MEM cycles; any gap in mem_valid_i or a
    // MEM grant restarts the count.
    always_comb begin
        starve_d = '0;
        if (mem_valid_i && !mem_ready_o) begin
            starve_d = starved ? starve_q : starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/amber128_writeback.sv
// amber128_writeback: producer side of the data register file write port.
// Arbitrates ALU and MEM results onto one registered write port and keeps a
// per-register busy scoreboard for RAW/WAW hazard detection at issue.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   issue_valid_i/issue_rd_i/issue_ready_o  destination reservation at issue
//   alu_valid_i/alu_rd_i/alu_data_i/alu_ready_o  ALU result handshake
//   mem_valid_i/mem_rd_i/mem_data_i/mem_ready_o  MEM result handshake
//   chk_ra_i/chk_rb_i, hazard_o           hazard query on regfile read addrs
//   wr_en_o/wr_addr_o/wr_data_o           registered regfile write port
//   busy_o                                scoreboard bits
//   err_o                                 sticky: write to a non-busy register
// Optional feature macro AMBER128_WB_BYPASS_EN: busy clears on the grant edge
// and the registered write port is exposed as a forwarding path
// (fwd_a_hit_o, fwd_b_hit_o, fwd_data_o).
module amber128_writeback
    import amber128_pkg::*;
#(
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    parameter int SC_W         = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      issue_valid_i,
    input  logic [DATA_REG_AW-1:0]    issue_rd_i,
    output logic                      issue_ready_o,
    input  logic                      alu_valid_i,
    input  logic [DATA_REG_AW-1:0]    alu_rd_i,
    input  logic [D_XLEN-1:0]         alu_data_i,
    output logic                      alu_ready_o,
    input  logic                      mem_valid_i,
    input  logic [DATA_REG_AW-1:0]    mem_rd_i,
    input  logic [D_XLEN-1:0]         mem_data_i,
    output logic                      mem_ready_o,
    input  logic [DATA_REG_AW-1:0]    chk_ra_i,
    input  logic [DATA_REG_AW-1:0]    chk_rb_i,
    output logic                      hazard_o,
`ifdef AMBER128_WB_BYPASS_EN
    output logic                      fwd_a_hit_o,
    output logic                      fwd_b_hit_o,
    output logic [D_XLEN-1:0]         fwd_data_o,
`endif
    output logic                      wr_en_o,
    output logic [DATA_REG_AW-1:0]    wr_addr_o,
    output logic [D_XLEN-1:0]         wr_data_o,
    output logic [DATA_REG_COUNT-1:0] busy_o,
    output logic                      err_o
);

    logic                      wr_en_q,   wr_en_d;
    logic [DATA_REG_AW-1:0]    wr_addr_q, wr_addr_d;
    logic [D_XLEN-1:0]         wr_data_q, wr_data_d;
    logic [DATA_REG_COUNT-1:0] busy_q,    busy_d;
    logic                      err_q,     err_d;

    amber128_wb_result_s alu_res, mem_res, gnt_res;
    logic                grant;
    logic                gnt_nz;
    logic                issue_acc;
    logic [DATA_REG_COUNT-1:0] set_vec, clr_vec;

    amber128_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SC_W         (SC_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alu_valid_i (alu_valid_i),
        .mem_valid_i (mem_valid_i),
        .alu_ready_o (alu_ready_o),
        .mem_ready_o (mem_ready_o)
    );

    assign alu_res = '{rd: alu_rd_i, data: alu_data_i};
    assign mem_res = '{rd: mem_rd_i, data: mem_data_i};

    // r0 is never reserved, so issuing to it never stalls.
    assign issue_ready_o = ~busy_q[issue_rd_i] | (issue_rd_i == REG_ZERO);
    assign issue_acc     = issue_valid_i & issue_ready_o & (issue_rd_i != REG_ZERO);
    assign hazard_o      = busy_q[chk_ra_i] | busy_q[chk_rb_i];

    always_comb begin
        gnt_res   = mem_ready_o ? mem_res : alu_res;
        grant     = alu_ready_o | mem_ready_o;
        gnt_nz    = grant & (gnt_res.rd != REG_ZERO);

        // Address/data load on any grant (even to r0); wr_en only for real writes.
        wr_en_d   = gnt_nz;
        wr_addr_d = grant ? gnt_res.rd   : wr_addr_q;
        wr_data_d = grant ? gnt_res.data : wr_data_q;

        set_vec = '0;
        clr_vec = '0;
        if (issue_acc) begin
            set_vec[issue_rd_i] = 1'b1;
        end
`ifdef AMBER128_WB_BYPASS_EN
        // The forwarding path covers the cycle the regfile is not yet written.
        if (gnt_nz) begin
            clr_vec[gnt_res.rd] = 1'b1;
        end
`else
        // Hold busy until the regfile has actually absorbed the write.
        if (wr_en_q) begin
            clr_vec[wr_addr_q] = 1'b1;
        end
`endif
        // Set after clear so a same-edge re-reservation wins.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;

        err_d = err_q | (gnt_nz & ~busy_q[gnt_res.rd]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

`ifdef AMBER128_WB_BYPASS_EN
    assign fwd_a_hit_o = wr_en_q & (wr_addr_q == chk_ra_i);
    assign fwd_b_hit_o = wr_en_q & (wr_addr_q == chk_rb_i);
    assign fwd_data_o  = wr_data_q;
`endif

endmodule

// File: tb/tb_amber128_writeback.sv
module tb_amber128_writeback;
    import amber128_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      issue_valid_i;
    logic [DATA_REG_AW-1:0]    issue_rd_i;
    logic                      issue_ready_o;
    logic                      alu_valid_i;
    logic [DATA_REG_AW-1:0]    alu_rd_i;
    logic [D_XLEN-1:0]         alu_data_i;
    logic                      alu_ready_o;
    logic                      mem_valid_i;
    logic [DATA_REG_AW-1:0]    mem_rd_i;
    logic [D_XLEN-1:0]         mem_data_i;
    logic                      mem_ready_o;
    logic [DATA_REG_AW-1:0]    chk_ra_i;
    logic [DATA_REG_AW-1:0]    chk_rb_i;
    logic                      hazard_o;
    logic                      wr_en_o;
    logic [DATA_REG_AW-1:0]    wr_addr_o;
    logic [D_XLEN-1:0]         wr_data_o;
    logic [DATA_REG_COUNT-1:0] busy_o;
    logic                      err_o;
`ifdef AMBER128_WB_BYPASS_EN
    logic                      fwd_a_hit_o;
    logic                      fwd_b_hit_o;
    logic [D_XLEN-1:0]         fwd_data_o;
`endif

    always #5 clk_i = ~clk_i;

    amber128_writeback dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_ready_o   (alu_ready_o),
        .mem_valid_i   (mem_valid_i),
        .mem_rd_i      (mem_rd_i),
        .mem_data_i    (mem_data_i),
        .mem_ready_o   (mem_ready_o),
        .chk_ra_i      (chk_ra_i),
        .chk_rb_i      (chk_rb_i),
        .hazard_o      (hazard_o),
`ifdef AMBER128_WB_BYPASS_EN
        .fwd_a_hit_o   (fwd_a_hit_o),
        .fwd_b_hit_o   (fwd_b_hit_o),
        .fwd_data_o    (fwd_data_o),
`endif
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adat;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] mdat;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        e_iready;
        logic        e_aready;
        logic        e_mready;
        logic        e_haz;
        logic        e_wen;
        logic [3:0]  e_waddr;
        logic [15:0] e_wdata;
        logic [15:0] e_busy;
        logic [15:0] e_busy_b;
        logic        e_err;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    int nchecks = 0;
    int nerrs   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i = 1'b0; issue_rd_i = '0;
        alu_valid_i   = 1'b0; alu_rd_i   = '0; alu_data_i = '0;
        mem_valid_i   = 1'b0; mem_rd_i   = '0; mem_data_i = '0;
        chk_ra_i      = '0;   chk_rb_i   = '0;
    endtask

    // Starvation sequence: pattern of mem_valid and expected MEM grants.
    logic st_mv [13] = '{1,1,1,1,1,1,1,0,1,1,1,1,1};
    logic st_mg [13] = '{0,0,0,0,1,0,0,0,0,0,0,0,1};

    initial begin
        logic [15:0] eb;
        logic [127:0] edat;

        //         iv ird  av ard adat     mv mrd mdat     ra rb  ir ar mr hz  wen wa  wdata    busy     busy_b   err
        tbl[0] = '{1, 4'd5, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 4'd0, 1, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0020, 16'h0020, 0};
        tbl[1] = '{1, 4'd7, 1, 4'd5, 16'hDEAD, 0, 4'd0, 16'h0000, 4'd5, 4'd7, 1, 1, 0, 1, 1, 4'd5, 16'hDEAD, 16'h00A0, 16'h0080, 0};
        tbl[2] = '{1, 4'd7, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd7, 4'd0, 0, 0, 0, 1, 0, 4'd5, 16'hDEAD, 16'h0080, 16'h0080, 0};
        tbl[3] = '{1, 4'd0, 1, 4'd0, 16'h1234, 0, 4'd0, 16'h0000, 4'd7, 4'd0, 1, 1, 0, 1, 0, 4'd0, 16'h1234, 16'h0080, 16'h0080, 0};
        tbl[4] = '{1, 4'd7, 0, 4'd0, 16'h0000, 1, 4'd7, 16'hBEEF, 4'd7, 4'd7, 0, 0, 1, 1, 1, 4'd7, 16'hBEEF, 16'h0080, 16'h0000, 0};
        tbl[5] = '{0, 4'd0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd0, 4'd0, 1, 0, 0, 0, 0, 4'd7, 16'hBEEF, 16'h0000, 16'h0000, 0};
        tbl[6] = '{0, 4'd0, 1, 4'd3, 16'h3333, 0, 4'd0, 16'h0000, 4'd3, 4'd0, 1, 1, 0, 0, 1, 4'd3, 16'h3333, 16'h0000, 16'h0000, 1};
        tbl[7] = '{0, 4'd0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd0, 4'd0, 1, 0, 0, 0, 0, 4'd3, 16'h3333, 16'h0000, 16'h0000, 1};
        tbl[8] = '{1, 4'd2, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd2, 4'd0, 1, 0, 0, 0, 0, 4'd3, 16'h3333, 16'h0004, 16'h0004, 1};
        tbl[9] = '{1, 4'd9, 1, 4'd2, 16'h2222, 0, 4'd0, 16'h0000, 4'd2, 4'd9, 1, 1, 0, 1, 1, 4'd2, 16'h2222, 16'h0204, 16'h0200, 1};

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset wr_en",   128'(wr_en_o),   128'(0));
        check("reset wr_addr", 128'(wr_addr_o), 128'(0));
        check("reset wr_data", 128'(wr_data_o), 128'(0));
        check("reset busy",    128'(busy_o),    128'(0));
        check("reset err",     128'(err_o),     128'(0));

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            issue_valid_i = tbl[i].iv;  issue_rd_i = tbl[i].ird;
            alu_valid_i   = tbl[i].av;  alu_rd_i   = tbl[i].ard; alu_data_i = D_XLEN'(tbl[i].adat);
            mem_valid_i   = tbl[i].mv;  mem_rd_i   = tbl[i].mrd; mem_data_i = D_XLEN'(tbl[i].mdat);
            chk_ra_i      = tbl[i].ra;  chk_rb_i   = tbl[i].rb;
            #2;
            check($sformatf("v%0d issue_ready", i), 128'(issue_ready_o), 128'(tbl[i].e_iready));
            check($sformatf("v%0d alu_ready", i),   128'(alu_ready_o),   128'(tbl[i].e_aready));
            check($sformatf("v%0d mem_ready", i),   128'(mem_ready_o),   128'(tbl[i].e_mready));
            check($sformatf("v%0d hazard", i),      128'(hazard_o),      128'(tbl[i].e_haz));
            @(posedge clk_i);
            #1;
`ifdef AMBER128_WB_BYPASS_EN
            eb = tbl[i].e_busy_b;
`else
            eb = tbl[i].e_busy;
`endif
            check($sformatf("v%0d wr_en", i),   128'(wr_en_o),   128'(tbl[i].e_wen));
            check($sformatf("v%0d wr_addr", i), 128'(wr_addr_o), 128'(tbl[i].e_waddr));
            check($sformatf("v%0d wr_data", i), 128'(wr_data_o), 128'(tbl[i].e_wdata));
            check($sformatf("v%0d busy", i),    128'(busy_o),    128'(eb));
            check($sformatf("v%0d err", i),     128'(err_o),     128'(tbl[i].e_err));
        end

        // Mid-cycle asynchronous reset with r2/r9 reserved and a write in flight.
        idle_inputs();
`ifdef AMBER128_WB_BYPASS_EN
        chk_ra_i = 4'd2; chk_rb_i = 4'd9;
        #1;
        check("fwd_a_hit", 128'(fwd_a_hit_o), 128'(1));
        check("fwd_b_hit", 128'(fwd_b_hit_o), 128'(0));
        check("fwd_data",  128'(fwd_data_o),  128'(16'h2222));
        chk_ra_i = '0; chk_rb_i = '0;
`endif
        #1;
        rst_ni = 1'b0;
        #1;
        check("async rst wr_en",   128'(wr_en_o),   128'(0));
        check("async rst wr_addr", 128'(wr_addr_o), 128'(0));
        check("async rst wr_data", 128'(wr_data_o), 128'(0));
        check("async rst busy",    128'(busy_o),    128'(0));
        check("async rst err",     128'(err_o),     128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Starvation: ALU valid every cycle, MEM mostly valid, both target r0.
        for (int c = 0; c < 13; c++) begin
            @(negedge clk_i);
            alu_valid_i = 1'b1; alu_rd_i = '0; alu_data_i = D_XLEN'(16'h0100 + c);
            mem_valid_i = st_mv[c]; mem_rd_i = '0; mem_data_i = D_XLEN'(16'h0F00);
            #2;
            check($sformatf("st%0d mem_ready", c), 128'(mem_ready_o), 128'(st_mg[c]));
            check($sformatf("st%0d alu_ready", c), 128'(alu_ready_o), 128'(!st_mg[c]));
            edat = st_mg[c] ? 128'(16'h0F00) : 128'(16'h0100 + c);
            @(posedge clk_i);
            #1;
            check($sformatf("st%0d wr_data", c), 128'(wr_data_o), edat);
            check($sformatf("st%0d wr_en", c),   128'(wr_en_o),   128'(0));
            check($sformatf("st%0d err", c),     128'(err_o),     128'(0));
        end
        @(negedge clk_i);
        idle_inputs();
        @(posedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/amber128_writeback.md
Name: amber128_writeback

Overview:
- Producer side of the data register file write port.
- Collects results from two execution sources: ALU (single-cycle) and MEM (long-latency load path). Arbitrates them onto the single registered write port (wr_en/wr_addr/wr_data).
- Keeps a per-register busy scoreboard so issue can detect RAW and WAW hazards.
- Sits between the execute units and amber128_regfile. Shares the regfile's read addresses for the hazard check.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles MEM may be refused while valid before it is granted over ALU.
- SC_W, 3: starvation counter width; SC_W must be at least clog2(STARVE_LIMIT+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- issue_valid_i  in  1  an instruction with a destination register is issuing.
- issue_rd_i  in  DATA_REG_AW  destination register of the issuing instruction.
- issue_ready_o  out  1  issue accepted (destination not busy).
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  DATA_REG_AW  ALU destination register.
- alu_data_i  in  D_XLEN  ALU result.
- alu_ready_o  out  1  ALU result granted this cycle.
- mem_valid_i  in  1  MEM result valid.
- mem_rd_i  in  DATA_REG_AW  MEM destination register.
- mem_data_i  in  D_XLEN  MEM result.
- mem_ready_o  out  1  MEM result granted this cycle.
- chk_ra_i  in  DATA_REG_AW  hazard query address A (same as regfile ra).
- chk_rb_i  in  DATA_REG_AW  hazard query address B (same as regfile rb).
- hazard_o  out  1  ra or rb has a pending write.
- wr_en_o  out  1  regfile write enable (registered).
- wr_addr_o  out  DATA_REG_AW  regfile write address (registered).
- wr_data_o  out  D_XLEN  regfile write data (registered).
- busy_o  out  DATA_REG_COUNT  scoreboard bits.
- err_o  out  1  sticky: a writeback targeted a non-busy, non-zero register.

Behaviour:
- Reset: wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, err_o=0, starve counter=0. Reset mid-operation drops all pending state; sources must re-present.
- Handshake: a transfer occurs on an edge where valid&ready is high. Ready may depend combinationally on valid. A source holds rd/data stable while valid and not ready.
- Arbitration:
  - ALU has priority.
  - mem_ready_o = mem_valid_i & (!alu_valid_i | starve==STARVE_LIMIT).
  - alu_ready_o = alu_valid_i & !mem_ready_o.
  - At most one grant per cycle.
- Starve counter: increments when mem_valid_i & !mem_ready_o; saturates at STARVE_LIMIT; clears on a MEM grant or when mem_valid_i=0.
- Output stage: one cycle latency, grant edge to wr_en_o.
  - wr_en_o <= grant & (granted rd != REG_ZERO).
  - wr_addr_o and wr_data_o load from the granted source whenever there is a grant.
  - No grant: wr_en_o <= 0.
- Scoreboard:
  - issue_ready_o = !busy[issue_rd_i] | (issue_rd_i==REG_ZERO).
  - An accepted issue sets busy[issue_rd_i]; never sets bit 0.
  - busy clear point: see Optional Feature.
  - Set and clear of the same register on one edge: set wins.
- hazard_o = busy[chk_ra_i] | busy[chk_rb_i]. busy[0] is constant 0.
- err_o: set on a grant whose rd != REG_ZERO and whose busy bit is 0. The write still proceeds. err_o clears only on reset.

Optional Feature:
- Macro: AMBER128_WB_BYPASS_EN.
- Without the macro: busy bit clears on the edge where wr_en_o=1 is consumed by the regfile (one cycle after grant). A hazard is reported until the regfile holds the data.
- With the macro:
  - busy bit clears on the grant edge.
  - Extra outputs fwd_a_hit_o, fwd_b_hit_o (1 bit) and fwd_data_o (D_XLEN).
  - fwd_x_hit_o = wr_en_o & (wr_addr_o==chk_rx_i). fwd_data_o = wr_data_o.
  - The consumer muxes the forwarded data over the stale regfile read. This saves one stall cycle per dependency.

Decomposition:
- amber128_pkg already provides D_XLEN, DATA_REG_AW, DATA_REG_COUNT and REG_ZERO.
- Add to amber128_pkg: amber128_wb_result_s {rd, data} for the source payload, and a default WB_STARVE_LIMIT.
- One sub-module: amber128_wb_arbiter (two-way priority arbiter plus starvation counter). Scoreboard and output register stay in the top.

Test Plan:
- Issue r5, ALU writes r5 = 0xDEAD -> next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEAD.
  - Without macro: busy_o[5] clears one cycle later.
  - With macro: busy_o[5] clears at grant and fwd_a_hit_o=1 when chk_ra_i=5.
- ALU and MEM valid every cycle, STARVE_LIMIT=4 -> ALU granted 4 cycles, MEM granted on the 5th, then the counter resets.
- r7 busy, issue_rd_i=7 -> issue_ready_o=0 until r7's writeback clears the bit. issue_rd_i=0 -> issue_ready_o=1 and busy_o unchanged.
- ALU writeback to r0 -> alu_ready_o=1, wr_en_o stays 0, err_o stays 0.
- Writeback to non-busy r3 -> write occurs and err_o=1, sticky until rst_ni low.
- Assert rst_ni low mid-stream with busy r2/r9 and wr_en_o=1 -> all outputs 0 immediately, asynchronously.
